// File: rtl/rf_writeback_stage.sv
// rf_writeback_stage: MEM/WB register, register-file write driver, same-cycle read forwarding
module rf_writeback_stage #(
  parameter int AWL = 5,
  parameter int DWL = 32
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           STALL,
  input  logic           FLUSH,
  input  logic           mem_valid,
  input  logic           mem_regwrite,
  input  logic           mem_memtoreg,
  input  logic [AWL-1:0] mem_rd,
  input  logic [DWL-1:0] mem_alu_result,
  input  logic [DWL-1:0] mem_load_data,
  output logic           WR,
  output logic [AWL-1:0] addr_WR,
  output logic [DWL-1:0] Din,
  input  logic [AWL-1:0] addr1,
  input  logic [AWL-1:0] addr2,
  input  logic [DWL-1:0] rf_dout1,
  input  logic [DWL-1:0] rf_dout2,
  output logic [DWL-1:0] rd1_fwd,
  output logic [DWL-1:0] rd2_fwd,
  output logic [15:0]    wb_count
);
  // An entry retires on any unstalled edge, including a flushing one
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      WR       <= 1'b0;
      addr_WR  <= '0;
      Din      <= '0;
      wb_count <= '0;
    end else begin
      if (WR && !STALL) wb_count <= wb_count + 16'd1;
      if (FLUSH) begin
        WR      <= 1'b0;
        addr_WR <= '0;
        Din     <= '0;
      end else if (!STALL) begin
        WR      <= mem_valid && mem_regwrite && (mem_rd != '0);
        addr_WR <= mem_rd;
        Din     <= mem_memtoreg ? mem_load_data : mem_alu_result;
      end
    end
  end
  // WR is never set for $0, so address 0 can never hit the bypass
  always_comb begin
    rd1_fwd = (WR && addr1 == addr_WR) ? Din : rf_dout1;
    rd2_fwd = (WR && addr2 == addr_WR) ? Din : rf_dout2;
  end
endmodule

// File: tb/tb_rf_writeback_stage.sv
// tb_rf_writeback_stage: randomized scoreboard bench for rf_writeback_stage
module tb_rf_writeback_stage;
  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        STALL = 1'b0, FLUSH = 1'b0;
  logic        mem_valid = 1'b0, mem_regwrite = 1'b0, mem_memtoreg = 1'b0;
  logic [4:0]  mem_rd = '0;
  logic [31:0] mem_alu_result = '0, mem_load_data = '0;
  logic        WR;
  logic [4:0]  addr_WR;
  logic [31:0] Din;
  logic [4:0]  addr1 = '0, addr2 = '0;
  logic [31:0] rf_dout1 = '0, rf_dout2 = '0;
  logic [31:0] rd1_fwd, rd2_fwd;
  logic [15:0] wb_count;

  typedef struct {
    logic        wr;
    logic [4:0]  addr;
    logic [31:0] din;
    int          cnt;
    logic [31:0] f1;
    logic [31:0] f2;
  } exp_t;

  exp_t q[$];
  int n_chk = 0, n_fail = 0;
  logic        m_wr = 1'b0;
  logic [4:0]  m_addr = '0;
  logic [31:0] m_din = '0;
  int          m_cnt = 0;

  rf_writeback_stage dut (
    .CLK(CLK), .RST(RST), .STALL(STALL), .FLUSH(FLUSH),
    .mem_valid(mem_valid), .mem_regwrite(mem_regwrite), .mem_memtoreg(mem_memtoreg),
    .mem_rd(mem_rd), .mem_alu_result(mem_alu_result), .mem_load_data(mem_load_data),
    .WR(WR), .addr_WR(addr_WR), .Din(Din),
    .addr1(addr1), .addr2(addr2), .rf_dout1(rf_dout1), .rf_dout2(rf_dout2),
    .rd1_fwd(rd1_fwd), .rd2_fwd(rd2_fwd), .wb_count(wb_count)
  );

  always #5 CLK = ~CLK;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Model: one retiring slot plus a retire tally modulo 2^16
  task automatic cycle(input logic st, input logic fl, input logic v, input logic rw,
                       input logic mt, input logic [4:0] rd, input logic [31:0] alu,
                       input logic [31:0] ld);
    exp_t e;
    @(negedge CLK);
    STALL = st; FLUSH = fl; mem_valid = v; mem_regwrite = rw; mem_memtoreg = mt;
    mem_rd = rd; mem_alu_result = alu; mem_load_data = ld;
    if (m_wr && !st) m_cnt = (m_cnt + 1) % 65536;
    if (fl) begin
      m_wr = 1'b0; m_addr = '0; m_din = '0;
    end else if (!st) begin
      m_wr = v && rw && rd != 0; m_addr = rd; m_din = mt ? ld : alu;
    end
    addr1 = $urandom_range(1) ? m_addr : 5'($urandom);
    addr2 = $urandom_range(1) ? m_addr : 5'($urandom);
    rf_dout1 = $urandom; rf_dout2 = $urandom;
    e.wr = m_wr; e.addr = m_addr; e.din = m_din; e.cnt = m_cnt;
    e.f1 = (m_wr && addr1 == m_addr) ? m_din : rf_dout1;
    e.f2 = (m_wr && addr2 == m_addr) ? m_din : rf_dout2;
    q.push_back(e);
  endtask

  task automatic load(input logic [4:0] rd, input logic [31:0] alu);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, rd, alu, $urandom);
  endtask

  task automatic settle();
    @(posedge CLK);
    #2;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    STALL = 0; FLUSH = 0; mem_valid = 0; mem_regwrite = 0; mem_memtoreg = 0;
    mem_rd = '0; mem_alu_result = '0; mem_load_data = '0;
    #2 RST = 1'b0;
    #1;
    chk("rst_wr", WR, 0);
    chk("rst_addr", addr_WR, 0);
    chk("rst_din", Din, 0);
    chk("rst_cnt", wb_count, 0);
    addr1 = 5'd4; rf_dout1 = 32'h5A5A0001;
    #1 chk("rst_fwd", rd1_fwd, 32'h5A5A0001);
    m_wr = 1'b0; m_addr = '0; m_din = '0; m_cnt = 0;
    #1 RST = 1'b1;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("wr", WR, e.wr);
        chk("addr_wr", addr_WR, e.addr);
        chk("din", Din, e.din);
        chk("wb_count", wb_count, e.cnt);
        chk("rd1_fwd", rd1_fwd, e.f1);
        chk("rd2_fwd", rd2_fwd, e.f2);
      end
    end
  end

  initial begin
    #12 RST = 1'b1;
    for (int i = 0; i < 4; i++) load(5'd7, $urandom);
    settle();
    chk("pre_rst_wr", WR, 1);
    chk("pre_rst_addr", addr_WR, 7);
    chk("pre_rst_cnt", wb_count, 3);
    do_reset();
    load(5'd5, 32'h00001234);
    settle();
    chk("alu_wr", WR, 1);
    chk("alu_addr", addr_WR, 5);
    chk("alu_din", Din, 32'h00001234);
    addr1 = 5'd5; rf_dout1 = 32'h0; addr2 = 5'd6; rf_dout2 = 32'hAA;
    #1;
    chk("alu_fwd1", rd1_fwd, 32'h00001234);
    chk("alu_fwd2", rd2_fwd, 32'hAA);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd16, 32'h1, 32'hDEADBEEF);
    settle();
    chk("ld_din", Din, 32'hDEADBEEF);
    chk("ld_addr", addr_WR, 16);
    chk("ld_cnt_before", wb_count, 1);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 32'hFFFFFFFF, 32'h0);
    settle();
    chk("z_wr", WR, 0);
    chk("z_cnt", wb_count, 2);
    addr1 = 5'd0; rf_dout1 = 32'h0;
    #1 chk("z_fwd", rd1_fwd, 32'h0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd8, 32'h77, 32'h0);
    settle();
    chk("z2_cnt", wb_count, 2);
    load(5'd9, 32'h99);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd11, $urandom, $urandom);
    settle();
    chk("st_addr", addr_WR, 9);
    chk("st_din", Din, 32'h99);
    chk("st_cnt", wb_count, 2);
    load(5'd12, 32'hC);
    settle();
    chk("st_release_cnt", wb_count, 3);
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd13, 32'hD, 32'h0);
    settle();
    chk("sf_wr", WR, 0);
    chk("sf_cnt", wb_count, 3);
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(4) == 0, $urandom_range(9) == 0, $urandom_range(3) != 0,
            $urandom_range(3) != 0, 1'($urandom), ($urandom_range(5) == 0) ? 5'd0 : 5'($urandom),
            $urandom, $urandom);
    do_reset();
    for (int i = 0; i < 65536; i++) load(5'd3, i);
    settle();
    chk("wrap_ffff", wb_count, 16'hFFFF);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd3, 32'h0, 32'h0);
    settle();
    chk("wrap_zero", wb_count, 16'h0000);
    settle();
    chk("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
